// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the buffered 8N1 UART transmitter.
//   - tx_state_e       : transmitter FSM states
//   - DATA_BITS        : payload bits per frame
//   - DEF_CLKS_PER_BIT : default bit period in clk cycles (12 MHz / 115200)
//   - START_LVL/STOP_LVL : line levels for the start and stop bits
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned DEF_CLKS_PER_BIT = 104;
  localparam logic        START_LVL        = 1'b0;
  localparam logic        STOP_LVL         = 1'b1;

endpackage

// File: rtl/uart_tx_buf_if.sv
// -----------------------------------------------------------------------------
// uart_tx_buf_if
//   Byte stream handshake between the dump manager (master) and the UART
//   transmitter (slave).
//   - tx_en    : master has a valid byte on tx_data (level)
//   - tx_data  : byte to send
//   - tx_ready : one-cycle pulse from the slave, tx_data was captured
// -----------------------------------------------------------------------------
interface uart_tx_buf_if;
  import uart_pkg::*;

  logic                 tx_en;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (
    output tx_en,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_en,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
//   Reloadable down-counter that marks serial bit boundaries. It counts from
//   CLKS_PER_BIT-1 down to 0; bit_done is high while the count is 0, and the
//   counter reloads on that edge, so bit_done recurs every CLKS_PER_BIT cycles.
//   restart reloads immediately, aligning the period to a frame start.
//   Ports:
//   - clk      : system clock
//   - rst      : asynchronous active-low reset
//   - restart  : reload the counter on this edge
//   - bit_done : current cycle is the last one of a bit period
// -----------------------------------------------------------------------------
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_done
);

  localparam int unsigned     CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= RELOAD;
    end else if (restart || (r_cnt == '0)) begin
      r_cnt <= RELOAD;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bit_done = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_buf.sv
// -----------------------------------------------------------------------------
// uart_tx_buf
//   Buffered 8N1 UART transmitter fed by the memory/register dump manager.
//   A one-byte hold register in front of the shift register lets the next
//   byte be queued while the current frame is on the line, so consecutive
//   frames go out with no idle gap.
//   Parameters:
//   - CLKS_PER_BIT : clk cycles per serial bit (>= 2)
//   - STOP_BITS    : stop bits per frame (1 or 2)
//   - CAP_GAP      : minimum clk edges between captures (>= 3)
//   Ports:
//   - clk  : system clock
//   - rst  : asynchronous active-low reset
//   - bus  : slave side of the tx_en/tx_data/tx_ready handshake
//   - txd  : serial line, idle high (registered)
//   - busy : hold register full or a frame in progress
// -----------------------------------------------------------------------------
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CAP_GAP      = 3
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_buf_if.slave  bus,
  output logic          txd,
  output logic          busy
);

  localparam int unsigned    GW         = $clog2(CAP_GAP + 1);
  localparam logic [GW-1:0]  GAP_RELOAD = GW'(CAP_GAP - 1);
  localparam int unsigned    IW         = $clog2(DATA_BITS);
  localparam logic [IW-1:0]  LAST_IDX   = IW'(DATA_BITS - 1);
  localparam logic [1:0]     LAST_STOP  = 2'(STOP_BITS - 1);

  tx_state_e            r_state;
  tx_state_e            w_state_nxt;
  logic [DATA_BITS-1:0] r_hold;
  logic [DATA_BITS-1:0] w_hold_nxt;
  logic                 r_hold_full;
  logic                 w_hold_full_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [GW-1:0]        r_gap;
  logic [GW-1:0]        w_gap_nxt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [1:0]           r_stop;
  logic [1:0]           w_stop_nxt;
  logic                 r_txd;
  logic                 w_txd_nxt;
  logic                 r_ready;

  logic                 w_cap;
  logic                 w_load;
  logic                 w_bit_done;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .restart  (w_load),
    .bit_done (w_bit_done)
  );

  // Capture uses pre-edge hold state: on the edge where the shifter empties
  // the hold register, r_hold_full is still 1 and capture is blocked. The gap
  // counter is loaded with CAP_GAP-1 so the next capture waits CAP_GAP edges,
  // long enough for the dump manager to update tx_data or drop tx_en.
  assign w_cap = bus.tx_en & ~r_hold_full & (r_gap == '0);

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_nxt      = r_hold;
    w_hold_full_nxt = r_hold_full;
    w_shift_nxt     = r_shift;
    w_gap_nxt       = r_gap;
    w_idx_nxt       = r_idx;
    w_stop_nxt      = r_stop;
    w_txd_nxt       = r_txd;
    w_load          = 1'b0;

    if (w_cap) begin
      w_gap_nxt = GAP_RELOAD;
    end else if (r_gap != '0) begin
      w_gap_nxt = r_gap - 1'b1;
    end

    if (w_cap) begin
      w_hold_nxt      = bus.tx_data;
      w_hold_full_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (r_hold_full) begin
          w_load = 1'b1;
        end
      end
      START: begin
        if (w_bit_done) begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
          w_txd_nxt   = r_shift[0];
        end
      end
      DATA: begin
        if (w_bit_done) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = STOP;
            w_stop_nxt  = '0;
            w_txd_nxt   = STOP_LVL;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_shift_nxt = r_shift >> 1;
            w_txd_nxt   = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_bit_done) begin
          if (r_stop == LAST_STOP) begin
            // A queued byte goes straight into the next start bit.
            if (r_hold_full) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_stop_nxt = r_stop + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_txd_nxt   = STOP_LVL;
      end
    endcase

    // Loading only happens with the hold register full, and capture only with
    // it empty, so these two updates of w_hold_full_nxt never collide.
    if (w_load) begin
      w_shift_nxt     = r_hold;
      w_hold_full_nxt = 1'b0;
      w_state_nxt     = START;
      w_txd_nxt       = START_LVL;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_gap       <= '0;
      r_idx       <= '0;
      r_stop      <= '0;
      r_txd       <= STOP_LVL;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_shift     <= w_shift_nxt;
      r_gap       <= w_gap_nxt;
      r_idx       <= w_idx_nxt;
      r_stop      <= w_stop_nxt;
      r_txd       <= w_txd_nxt;
      r_ready     <= w_cap;
    end
  end

  assign bus.tx_ready = r_ready;
  assign txd          = r_txd;
  assign busy         = (r_state != IDLE) | r_hold_full;

endmodule

// File: tb/tb_uart_tx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buf
//   Scoreboard bench for uart_tx_buf. Stimulus pushes the byte it presented
//   at each capture; a line monitor decodes frames from txd and pops/compares.
//   A second instance with two stop bits is measured directly on its line.
// -----------------------------------------------------------------------------
module tb_uart_tx_buf;
  import uart_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int          FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n;
  logic txd1, busy1, txd2, busy2;

  uart_tx_buf_if bus1 ();
  uart_tx_buf_if bus2 ();

  uart_tx_buf #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (1),
    .CAP_GAP      (3)
  ) dut1 (
    .clk  (clk),
    .rst  (rst_n),
    .bus  (bus1),
    .txd  (txd1),
    .busy (busy1)
  );

  uart_tx_buf #(
    .CLKS_PER_BIT (CPB),
    .STOP_BITS    (2),
    .CAP_GAP      (3)
  ) dut2 (
    .clk  (clk),
    .rst  (rst_n),
    .bus  (bus2),
    .txd  (txd2),
    .busy (busy2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int   n_total     = 0;
  int   n_pass      = 0;
  int   frames_seen = 0;
  int   ready_cnt   = 0;
  logic [7:0] stim [4];

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
  endtask

  always @(negedge clk) if (bus1.tx_ready === 1'b1) ready_cnt++;

  // Line monitor for dut1: sample every cycle of a frame, require each bit
  // to be stable for CPB samples, then compare against the scoreboard.
  initial begin : monitor
    int         mcyc;
    int         prev_end;
    int         start;
    logic [9:0] bits;
    logic [3:0] bi;
    bit         glitch;
    bit         aborted;
    exp_t       e;
    mcyc     = 0;
    prev_end = -100;
    forever begin
      @(negedge clk);
      mcyc++;
      if (rst_n === 1'b1 && txd1 === 1'b0) begin
        start   = mcyc;
        bits    = '0;
        glitch  = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k > 0) begin
            @(negedge clk);
            mcyc++;
          end
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          bi = 4'(k / CPB);
          if (k % CPB == 0) bits[bi] = txd1;
          else if (txd1 !== bits[bi]) glitch = 1'b1;
        end
        if (!aborted) begin
          frames_seen++;
          check("frame_format", int'({glitch, bits[0], bits[9]}), 1);
          check("frame_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_data", int'(bits[8:1]), int'(e.data));
            if (e.b2b) check("frame_no_gap", start - prev_end, 1);
          end
          prev_end = mcyc;
        end
      end
    end
  end

  task automatic wait_ready(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((which == 1 ? bus1.tx_ready : bus2.tx_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle1(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy1 === 1'b0) break;
    end
    check(name, int'(busy1), 0);
    repeat (4) @(negedge clk);
  endtask

  // Dump-manager model: next byte after the edge following tx_ready, tx_en
  // dropped drop_edges edges after the final pulse.
  task automatic send_stream(input int n, input int drop_edges, input string tag);
    bit   ok;
    exp_t e;
    @(posedge clk);
    #1;
    bus1.tx_data = stim[0];
    bus1.tx_en   = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_ready(1, ok);
      check({tag, "_ready"}, int'(ok), 1);
      if (!ok) break;
      e.data = stim[i];
      e.b2b  = (i > 0);
      exp_q.push_back(e);
      if (i < n - 1) begin
        @(posedge clk);
        #1;
        bus1.tx_data = stim[i + 1];
      end
    end
    repeat (drop_edges) @(posedge clk);
    #1;
    bus1.tx_en = 1'b0;
  endtask

  task automatic count_run2(input logic lvl, input bit need_busy, output int n);
    n = 0;
    while (n < 400 && txd2 === lvl && (!need_busy || busy2 === 1'b1)) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit   ok;
    int   r0, f0, caps, c1, c2, lows;
    logic [7:0] smp;
    exp_t e;

    rst_n        = 1'b1;
    bus1.tx_en   = 1'b0;
    bus1.tx_data = '0;
    bus2.tx_en   = 1'b0;
    bus2.tx_data = '0;
    c1 = 0;
    c2 = 0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_txd", int'(txd1), 1);
    check("reset_busy", int'(busy1), 0);
    check("reset_ready", int'(bus1.tx_ready), 0);
    check("reset_txd2", int'(txd2), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5, tx_en for one cycle.
    r0 = ready_cnt;
    @(posedge clk);
    #1;
    bus1.tx_data = 8'hA5;
    bus1.tx_en   = 1'b1;
    e.data = 8'hA5;
    e.b2b  = 1'b0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus1.tx_en = 1'b0;
    wait_ready(1, ok);
    check("single_ready", int'(ok), 1);
    @(negedge clk);
    check("single_ready_width", int'(bus1.tx_ready), 0);
    check("single_start_latency", int'(txd1), 0);
    repeat (39) @(negedge clk);
    check("single_busy_last_stop", int'(busy1), 1);
    @(negedge clk);
    check("single_busy_after", int'(busy1), 0);
    repeat (4) @(negedge clk);
    check("single_ready_count", ready_cnt - r0, 1);

    // Burst 0x11,0x22,0x33, tx_en dropped 2 edges after the last pulse.
    r0 = ready_cnt;
    f0 = frames_seen;
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33; stim[3] = 8'h00;
    send_stream(3, 2, "burst");
    wait_idle1("burst_idle");
    check("burst_ready_count", ready_cnt - r0, 3);
    check("burst_frames", frames_seen - f0, 3);

    // Register dump 0xEF,0xBE,0xAD,0xDE, tx_en dropped 3 edges after the last pulse.
    r0 = ready_cnt;
    f0 = frames_seen;
    stim[0] = 8'hEF; stim[1] = 8'hBE; stim[2] = 8'hAD; stim[3] = 8'hDE;
    send_stream(4, 3, "dump");
    wait_idle1("dump_idle");
    check("dump_ready_count", ready_cnt - r0, 4);
    check("dump_frames", frames_seen - f0, 4);

    // Data noise: tx_data changes every cycle with tx_en held.
    r0 = ready_cnt;
    f0 = frames_seen;
    @(posedge clk);
    #1;
    bus1.tx_data = 8'h3C;
    bus1.tx_en   = 1'b1;
    caps = 0;
    for (int c = 0; c < 300 && caps < 3; c++) begin
      @(posedge clk);
      smp = bus1.tx_data;
      #1;
      bus1.tx_data = bus1.tx_data + 8'h4B;
      @(negedge clk);
      if (bus1.tx_ready === 1'b1) begin
        caps++;
        e.data = smp;
        e.b2b  = (caps > 1);
        exp_q.push_back(e);
        if (caps == 1) c1 = c;
        if (caps == 2) c2 = c;
      end
    end
    @(posedge clk);
    #1;
    bus1.tx_en = 1'b0;
    check("noise_captures", caps, 3);
    check("noise_cap_gap", c2 - c1, 3);
    wait_idle1("noise_idle");
    check("noise_frames", frames_seen - f0, 3);

    // Reset during data bit 3 of 0x5A.
    r0 = ready_cnt;
    @(posedge clk);
    #1;
    bus1.tx_data = 8'h5A;
    bus1.tx_en   = 1'b1;
    @(posedge clk);
    #1;
    bus1.tx_en = 1'b0;
    wait_ready(1, ok);
    check("rst_ready", int'(ok), 1);
    repeat (14) @(negedge clk);
    check("rst_pre_bit2", int'(txd1), 0);
    repeat (4) @(negedge clk);
    check("rst_pre_bit3", int'(txd1), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_txd", int'(txd1), 1);
    check("rst_async_busy", int'(busy1), 0);
    check("rst_async_ready", int'(bus1.tx_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd1 !== 1'b1) lows++;
    end
    check("rst_line_idle", lows, 0);
    check("rst_busy_after", int'(busy1), 0);
    check("rst_ready_count", ready_cnt - r0, 1);

    // Two stop bits on dut2: 0xFF then queued 0x00.
    fork
      begin : drv2
        bit ok2;
        @(posedge clk);
        #1;
        bus2.tx_data = 8'hFF;
        bus2.tx_en   = 1'b1;
        wait_ready(2, ok2);
        check("stop2_ready_ff", int'(ok2), 1);
        @(posedge clk);
        #1;
        bus2.tx_data = 8'h00;
        wait_ready(2, ok2);
        check("stop2_ready_00", int'(ok2), 1);
        repeat (2) @(posedge clk);
        #1;
        bus2.tx_en = 1'b0;
      end
      begin : line2
        int l1, h1, l2, s2;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (txd2 === 1'b0) break;
        end
        count_run2(1'b0, 1'b0, l1);
        count_run2(1'b1, 1'b0, h1);
        count_run2(1'b0, 1'b0, l2);
        count_run2(1'b1, 1'b1, s2);
        check("stop2_start_len", l1, 4);
        check("stop2_ff_data_plus_stop", h1, 40);
        check("stop2_00_start_data", l2, 36);
        check("stop2_final_stop", s2, 8);
      end
    join
    repeat (4) @(negedge clk);
    check("stop2_idle", int'(busy2), 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
Name: uart_tx_buf

Overview:
Byte-serial UART transmitter that sits directly downstream of the memory/register dump manager. It consumes that manager's tx_en/tx_data stream and returns a one-cycle tx_ready capture pulse. A hold register plus a shift register give back-to-back 8N1 frames with no idle gap. It drives the board TXD pin.

Parameters:
CLKS_PER_BIT, 104, clk cycles per serial bit (12 MHz / 115200); must be >= 2.
STOP_BITS, 1, number of stop bits (1 or 2).
CAP_GAP, 3, minimum clk edges between successive captures; must be >= 3.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
tx_en  in  1  upstream has a valid byte on tx_data; level, held for the whole stream.
tx_data  in  8  byte to send.
tx_ready  out  1  one-cycle pulse: tx_data was captured on the previous edge; upstream may present the next byte.
txd  out  1  serial line, idle high.
busy  out  1  hold register full or frame in progress.

Behaviour:
- Reset (rst=0, asynchronous): txd=1, tx_ready=0, busy=0, hold empty, FSM=IDLE, gap counter satisfied so the first capture is immediate.
- Capture happens at a clk edge when all of the following hold:
  - tx_en=1 (value sampled at that edge);
  - hold is empty;
  - at least CAP_GAP edges have passed since the previous capture.
- On capture: hold<=tx_data, hold marked full, tx_ready=1 for exactly the following cycle.
- tx_data is ignored at every other time.
- CAP_GAP=3 is the minimum for memmgr compatibility:
  - memmgr updates tx_data on the edge after the tx_ready pulse.
  - It may drop tx_en up to 2 edges later.
  - A smaller gap risks re-sending stale data or capturing a byte after the stream has ended.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if hold is full, load the shifter from hold, mark hold empty and go to START. txd goes low on the same edge (txd is registered).
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; a 3-bit index counts 0..7, then go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. At the final stop cycle, if hold is full, go directly to START with the shifter reloaded (no idle gap); otherwise go to IDLE.
- Bit timer: counts down from CLKS_PER_BIT-1 to 0, reloads on every bit boundary, and is width-sized by $clog2(CLKS_PER_BIT).
- busy = (FSM != IDLE) | hold_full. It is combinational from registered state.
- tx_en dropping mid-frame: the current frame and any held byte complete normally.
- Capture on the same edge the shifter empties hold: the shifter takes the old hold; capture is blocked that edge because the hold_full check uses pre-edge state.
- Reset mid-frame: the line returns high immediately and no partial frame resumes after release.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE/START/DATA/STOP), DATA_BITS=8, default CLKS_PER_BIT=104, START_LVL=0, STOP_LVL=1.
- One natural sub-module, uart_bit_timer: a reloadable down-counter producing a bit_done pulse, with clk, rst, restart, bit_done ports and a CLKS_PER_BIT parameter.
- The FSM, hold register and capture-gap counter live in uart_tx_buf.

Test Plan:
- Test parameters unless noted: CLKS_PER_BIT=4, STOP_BITS=1, CAP_GAP=3.
- Single byte: tx_en=1, tx_data=0xA5 for 1 cycle after reset -> tx_ready pulses 1 cycle; txd sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); busy low after.
- Burst as memmgr read: 0x11, 0x22, 0x33, each updated on the edge after tx_ready; tx_en dropped 2 edges after the third tx_ready -> exactly 3 frames, back-to-back (no idle gap), no 4th tx_ready.
- Register-dump pattern: 4 bytes 0xEF, 0xBE, 0xAD, 0xDE; after the 3rd tx_ready, byte 0xDE is presented next edge and tx_en dropped 3 edges after the pulse -> all 4 frames sent in order.
- Reset mid-frame: rst=0 during data bit 3 of 0x5A -> txd=1, busy=0, tx_ready=0 asynchronously; after release with tx_en=0, txd stays 1 for 100 cycles.
- Data noise: tx_data toggled every cycle while hold is full -> transmitted bytes equal only the values present at capture edges.
- STOP_BITS=2: byte 0xFF -> stop-high interval of 8 cycles before the next start bit of a queued 0x00.
